// File: rtl/nvdla_dbb_sched_pkg.sv
// Shared types and constants for the NVDLA DBB burst scheduler.
package nvdla_dbb_sched_pkg;

    localparam int unsigned NVDLA_DBB_MAX_BEATS = 16;
    localparam int unsigned DBB_CNT_W           = $clog2(NVDLA_DBB_MAX_BEATS);

    typedef enum logic [2:0] {
        SCHED_IDLE,
        SCHED_WR_START,
        SCHED_WR_DATA,
        SCHED_WR_WAIT,
        SCHED_WR_RESP,
        SCHED_RD_START,
        SCHED_RD_DATA,
        SCHED_RD_WAIT
    } state_dbb_sched_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  beats;
        logic        write;
    } ctrl_dbb_sched_t;

    // DBB lengths are encoded as beats-1.
    function automatic logic [4:0] len_to_beats(input logic [DBB_CNT_W-1:0] len);
        return {1'b0, len} + 5'd1;
    endfunction

endpackage

// File: rtl/nvdla_dbb_rr_arb.sv
// Two-way round-robin arbiter (write vs read) with a registered last-grant pointer.
module nvdla_dbb_rr_arb (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output logic gnt_wr_o,
    output logic gnt_rd_o
);

    logic last_rd_q;

    always_comb begin
        gnt_wr_o = 1'b0;
        gnt_rd_o = 1'b0;
        if (en_i) begin
            if (req_wr_i && req_rd_i) begin
                gnt_rd_o = !last_rd_q;
                gnt_wr_o = last_rd_q;
            end else begin
                gnt_wr_o = req_wr_i;
                gnt_rd_o = req_rd_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            last_rd_q <= 1'b0;
        end else if (gnt_rd_o) begin
            last_rd_q <= 1'b1;
        end else if (gnt_wr_o) begin
            last_rd_q <= 1'b0;
        end
    end

endmodule

// File: rtl/nvdla_dbb_sched.sv
// Sequences NVDLA DBB read/write bursts onto the HWPE streamer pair, one at a time.
// Optional protocol checking is enabled by defining NVDLA_DBB_SCHED_ERR_EN.
module nvdla_dbb_sched
    import nvdla_dbb_sched_pkg::*;
#(
    parameter int unsigned MEMIF_WIDTH = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        wr_req_valid_i,
    output logic        wr_req_ready_o,
    input  logic [31:0] wr_req_addr_i,
    input  logic [3:0]  wr_req_len_i,
    input  logic [7:0]  wr_req_id_i,
    input  logic        rd_req_valid_i,
    output logic        rd_req_ready_o,
    input  logic [31:0] rd_req_addr_i,
    input  logic [3:0]  rd_req_len_i,
    input  logic [7:0]  rd_req_id_i,
    input  logic        wdat_valid_i,
    output logic        wdat_ready_o,
    input  logic        wdat_last_i,
    output logic        wrsp_valid_o,
    input  logic        wrsp_ready_i,
    output logic [7:0]  wrsp_id_o,
    output logic        rdat_valid_o,
    input  logic        rdat_ready_i,
    output logic        rdat_last_o,
    output logic [7:0]  rdat_id_o,
    output logic        strm_wdat_valid_o,
    input  logic        strm_wdat_ready_i,
    input  logic        strm_rdat_valid_i,
    output logic        strm_rdat_ready_o,
    output logic        strm_start_o,
    output logic        strm_write_o,
    output logic [31:0] strm_addr_o,
    output logic [4:0]  strm_beats_o,
    input  logic        strm_done_i,
    output logic        busy_o,
    output logic        err_o
);

    if ((MEMIF_WIDTH % 8) != 0) begin : g_bad_width
        $error("MEMIF_WIDTH must be a whole number of bytes");
    end

    state_dbb_sched_t     state_q;
    ctrl_dbb_sched_t      ctrl_q;
    logic [DBB_CNT_W-1:0] cnt_q;
    logic [DBB_CNT_W-1:0] len_q;
    logic [7:0]           id_q;
    logic                 done_seen_q;
    logic                 err_q;

    logic arb_en, gnt_wr, gnt_rd;
    logic in_wdat, in_rdat, wbeat, rbeat, cnt_last, post_start, done_now, err_set;

    // Grants are suppressed while reset/clear is asserted so every output reads 0.
    assign arb_en = enable_i && rst_ni && !clear_i && (state_q == SCHED_IDLE);

    nvdla_dbb_rr_arb u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (clear_i),
        .en_i     (arb_en),
        .req_wr_i (wr_req_valid_i),
        .req_rd_i (rd_req_valid_i),
        .gnt_wr_o (gnt_wr),
        .gnt_rd_o (gnt_rd)
    );

    assign wr_req_ready_o = gnt_wr;
    assign rd_req_ready_o = gnt_rd;

    assign in_wdat    = (state_q == SCHED_WR_DATA);
    assign in_rdat    = (state_q == SCHED_RD_DATA);
    assign cnt_last   = (cnt_q == len_q);
    assign post_start = in_wdat || in_rdat || (state_q == SCHED_WR_WAIT) ||
                        (state_q == SCHED_RD_WAIT);
    assign done_now   = done_seen_q || strm_done_i;

    assign strm_wdat_valid_o = in_wdat && wdat_valid_i;
    assign wdat_ready_o      = in_wdat && strm_wdat_ready_i;
    assign wbeat             = in_wdat && wdat_valid_i && strm_wdat_ready_i;

    assign rdat_valid_o      = in_rdat && strm_rdat_valid_i;
    assign strm_rdat_ready_o = in_rdat && rdat_ready_i;
    assign rbeat             = in_rdat && strm_rdat_valid_i && rdat_ready_i;
    assign rdat_last_o       = in_rdat && cnt_last;
    assign rdat_id_o         = in_rdat ? id_q : 8'h00;

    assign wrsp_valid_o = (state_q == SCHED_WR_RESP);
    assign wrsp_id_o    = wrsp_valid_o ? id_q : 8'h00;

    assign strm_start_o = (state_q == SCHED_WR_START) || (state_q == SCHED_RD_START);
    assign strm_write_o = strm_start_o && ctrl_q.write;
    assign strm_addr_o  = ctrl_q.addr;
    assign strm_beats_o = ctrl_q.beats;
    assign busy_o       = (state_q != SCHED_IDLE);
    assign err_o        = err_q;

`ifdef NVDLA_DBB_SCHED_ERR_EN
    assign err_set = (wbeat && (wdat_last_i != cnt_last)) ||
                     (post_start && strm_done_i && done_seen_q);
`else
    logic unused_wdat_last;
    assign unused_wdat_last = wdat_last_i;
    assign err_set          = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q     <= SCHED_IDLE;
            ctrl_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            id_q        <= '0;
            done_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (post_start && strm_done_i) done_seen_q <= 1'b1;
            if (err_set) err_q <= 1'b1;
            unique case (state_q)
                SCHED_IDLE: begin
                    if (gnt_wr) begin
                        ctrl_q      <= '{addr: wr_req_addr_i, beats: len_to_beats(wr_req_len_i),
                                         write: 1'b1};
                        len_q       <= wr_req_len_i;
                        id_q        <= wr_req_id_i;
                        cnt_q       <= '0;
                        done_seen_q <= 1'b0;
                        state_q     <= SCHED_WR_START;
                    end else if (gnt_rd) begin
                        ctrl_q      <= '{addr: rd_req_addr_i, beats: len_to_beats(rd_req_len_i),
                                         write: 1'b0};
                        len_q       <= rd_req_len_i;
                        id_q        <= rd_req_id_i;
                        cnt_q       <= '0;
                        done_seen_q <= 1'b0;
                        state_q     <= SCHED_RD_START;
                    end
                end
                SCHED_WR_START: state_q <= SCHED_WR_DATA;
                SCHED_WR_DATA: begin
                    if (wbeat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_last) state_q <= SCHED_WR_WAIT;
                    end
                end
                SCHED_WR_WAIT: if (done_now) state_q <= SCHED_WR_RESP;
                SCHED_WR_RESP: if (wrsp_ready_i) state_q <= SCHED_IDLE;
                SCHED_RD_START: state_q <= SCHED_RD_DATA;
                SCHED_RD_DATA: begin
                    if (rbeat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_last) state_q <= done_seen_q ? SCHED_IDLE : SCHED_RD_WAIT;
                    end
                end
                SCHED_RD_WAIT: if (done_now) state_q <= SCHED_IDLE;
                default: state_q <= SCHED_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvdla_dbb_sched.sv
// Randomised self-checking bench for nvdla_dbb_sched against a burst-level reference model.
module tb_nvdla_dbb_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni, clear_i, enable_i;
    logic        wr_req_valid_i, wr_req_ready_o;
    logic [31:0] wr_req_addr_i;
    logic [3:0]  wr_req_len_i;
    logic [7:0]  wr_req_id_i;
    logic        rd_req_valid_i, rd_req_ready_o;
    logic [31:0] rd_req_addr_i;
    logic [3:0]  rd_req_len_i;
    logic [7:0]  rd_req_id_i;
    logic        wdat_valid_i, wdat_ready_o, wdat_last_i;
    logic        wrsp_valid_o, wrsp_ready_i;
    logic [7:0]  wrsp_id_o;
    logic        rdat_valid_o, rdat_ready_i, rdat_last_o;
    logic [7:0]  rdat_id_o;
    logic        strm_wdat_valid_o, strm_wdat_ready_i;
    logic        strm_rdat_valid_i, strm_rdat_ready_o;
    logic        strm_start_o, strm_write_o;
    logic [31:0] strm_addr_o;
    logic [4:0]  strm_beats_o;
    logic        strm_done_i, busy_o, err_o;

    nvdla_dbb_sched #(.MEMIF_WIDTH(64)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .clear_i           (clear_i),
        .enable_i          (enable_i),
        .wr_req_valid_i    (wr_req_valid_i),
        .wr_req_ready_o    (wr_req_ready_o),
        .wr_req_addr_i     (wr_req_addr_i),
        .wr_req_len_i      (wr_req_len_i),
        .wr_req_id_i       (wr_req_id_i),
        .rd_req_valid_i    (rd_req_valid_i),
        .rd_req_ready_o    (rd_req_ready_o),
        .rd_req_addr_i     (rd_req_addr_i),
        .rd_req_len_i      (rd_req_len_i),
        .rd_req_id_i       (rd_req_id_i),
        .wdat_valid_i      (wdat_valid_i),
        .wdat_ready_o      (wdat_ready_o),
        .wdat_last_i       (wdat_last_i),
        .wrsp_valid_o      (wrsp_valid_o),
        .wrsp_ready_i      (wrsp_ready_i),
        .wrsp_id_o         (wrsp_id_o),
        .rdat_valid_o      (rdat_valid_o),
        .rdat_ready_i      (rdat_ready_i),
        .rdat_last_o       (rdat_last_o),
        .rdat_id_o         (rdat_id_o),
        .strm_wdat_valid_o (strm_wdat_valid_o),
        .strm_wdat_ready_i (strm_wdat_ready_i),
        .strm_rdat_valid_i (strm_rdat_valid_i),
        .strm_rdat_ready_o (strm_rdat_ready_o),
        .strm_start_o      (strm_start_o),
        .strm_write_o      (strm_write_o),
        .strm_addr_o       (strm_addr_o),
        .strm_beats_o      (strm_beats_o),
        .strm_done_i       (strm_done_i),
        .busy_o            (busy_o),
        .err_o             (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_last_rd = 1'b0;  // reference: the last grant went to read
    bit exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise the requested valids and wait for a grant; returns the model's winner.
    task automatic issue(input bit do_wr, input bit do_rd, output bit got_wr);
        bit exp_wr;
        bit seen;
        seen = 1'b0;
        wr_req_valid_i = do_wr;
        rd_req_valid_i = do_rd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_req_ready_o || rd_req_ready_o) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check_eq("grant_seen", 32'(seen), 1);
        exp_wr = (do_wr && do_rd) ? model_last_rd : do_wr;
        check_eq("grant_excl", 32'(wr_req_ready_o & rd_req_ready_o), 0);
        check_eq("grant_wr", 32'(wr_req_ready_o), 32'(exp_wr));
        check_eq("grant_rd", 32'(rd_req_ready_o), 32'(!exp_wr));
        got_wr = exp_wr;
        model_last_rd = !exp_wr;
        step();
        wr_req_valid_i = 1'b0;
        rd_req_valid_i = 1'b0;
    endtask

    // Runs one granted burst from the START cycle back to IDLE.
    task automatic serve(input bit is_wr, input logic [3:0] len, input logic [7:0] id,
                         input logic [31:0] addr, input bit early_done, input bit bp,
                         input int bad_idx);
        int  beats;
        int  cyc;
        bit  hs;
        bit  seen;
        @(negedge clk);
        check_eq("start", 32'(strm_start_o), 1);
        check_eq("start_write", 32'(strm_write_o), 32'(is_wr));
        check_eq("start_addr", strm_addr_o, addr);
        check_eq("start_beats", 32'(strm_beats_o), 32'(len) + 1);
        check_eq("busy", 32'(busy_o), 1);
        step();
        if (early_done) strm_done_i = 1'b1;
        @(negedge clk);
        check_eq("start_pulse", 32'(strm_start_o), 0);
        step();
        strm_done_i = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats <= int'(len) && cyc < 300) begin
            if (is_wr) begin
                wdat_valid_i      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                strm_wdat_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                wdat_last_i       = (beats == int'(len)) || (beats == bad_idx);
            end else begin
                strm_rdat_valid_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                rdat_ready_i      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            if (is_wr) begin
                check_eq("wv_pass", 32'(strm_wdat_valid_o), 32'(wdat_valid_i));
                check_eq("wr_pass", 32'(wdat_ready_o), 32'(strm_wdat_ready_i));
                hs = wdat_valid_i && strm_wdat_ready_i;
            end else begin
                check_eq("rv_pass", 32'(rdat_valid_o), 32'(strm_rdat_valid_i));
                check_eq("rr_pass", 32'(strm_rdat_ready_o), 32'(rdat_ready_i));
                check_eq("rd_id", 32'(rdat_id_o), 32'(id));
                check_eq("rd_last", 32'(rdat_last_o), 32'(beats == int'(len)));
                hs = strm_rdat_valid_i && rdat_ready_i;
            end
            if (hs) beats++;
            step();
            cyc++;
        end
        check_eq("beat_count", 32'(beats), 32'(len) + 1);
        // Offer one more beat: the data gate must already be closed.
        wdat_valid_i      = is_wr;
        strm_wdat_ready_i = is_wr;
        wdat_last_i       = 1'b0;
        strm_rdat_valid_i = !is_wr;
        rdat_ready_i      = !is_wr;
        @(negedge clk);
        check_eq("wdat_gated", 32'(strm_wdat_valid_o | wdat_ready_o), 0);
        check_eq("rdat_gated", 32'(rdat_valid_o | strm_rdat_ready_o), 0);
        wdat_valid_i      = 1'b0;
        strm_wdat_ready_i = 1'b0;
        strm_rdat_valid_i = 1'b0;
        rdat_ready_i      = 1'b0;
        if (is_wr) begin
            check_eq("wrsp_early", 32'(wrsp_valid_o), 0);
            step();
            if (!early_done) begin
                strm_done_i = 1'b1;
                step();
                strm_done_i = 1'b0;
            end
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (wrsp_valid_o) begin
                    seen = 1'b1;
                    break;
                end
                step();
            end
            check_eq("wrsp_seen", 32'(seen), 1);
            for (int i = 0; i < 3; i++) begin
                check_eq("wrsp_hold", 32'(wrsp_valid_o), 1);
                check_eq("wrsp_id", 32'(wrsp_id_o), 32'(id));
                step();
                @(negedge clk);
            end
            wrsp_ready_i = 1'b1;
            check_eq("wrsp_hold", 32'(wrsp_valid_o), 1);
            check_eq("wrsp_id", 32'(wrsp_id_o), 32'(id));
            step();
            wrsp_ready_i = 1'b0;
            @(negedge clk);
            check_eq("wr_idle", 32'(busy_o), 0);
            check_eq("wrsp_drop", 32'(wrsp_valid_o), 0);
        end else begin
            if (early_done) begin
                check_eq("rd_direct_idle", 32'(busy_o), 0);
            end else begin
                step();
                strm_done_i = 1'b1;
                step();
                strm_done_i = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (!busy_o) begin
                        seen = 1'b1;
                        break;
                    end
                    step();
                end
                check_eq("rd_idle", 32'(seen), 1);
            end
        end
        check_eq("err", 32'(err_o), 32'(exp_err));
        step();
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        model_last_rd = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          gw;
        bit          dw, dr;
        logic [3:0]  ln;
        rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1;
        wr_req_valid_i = 1'b1; rd_req_valid_i = 1'b1;
        wr_req_addr_i = '0; wr_req_len_i = '0; wr_req_id_i = '0;
        rd_req_addr_i = '0; rd_req_len_i = '0; rd_req_id_i = '0;
        wdat_valid_i = 1'b0; wdat_last_i = 1'b0; wrsp_ready_i = 1'b0; rdat_ready_i = 1'b0;
        strm_wdat_ready_i = 1'b0; strm_rdat_valid_i = 1'b0; strm_done_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_wr_ready", 32'(wr_req_ready_o), 0);
        check_eq("rst_rd_ready", 32'(rd_req_ready_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_start", 32'(strm_start_o | strm_write_o), 0);
        check_eq("rst_addr", strm_addr_o, 0);
        check_eq("rst_beats", 32'(strm_beats_o), 0);
        check_eq("rst_wrsp", 32'(wrsp_valid_o), 0);
        check_eq("rst_rdat", 32'(rdat_valid_o), 0);
        check_eq("rst_err", 32'(err_o), 0);
        wr_req_valid_i = 1'b0;
        rd_req_valid_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step();

        // Ties from reset alternate starting with read.
        for (int k = 0; k < 4; k++) begin
            wr_req_addr_i = 32'h2000 + 32'(k) * 32'h100; wr_req_len_i = 4'd1;
            wr_req_id_i = 8'h20 + 8'(k);
            rd_req_addr_i = 32'h3000 + 32'(k) * 32'h100; rd_req_len_i = 4'd1;
            rd_req_id_i = 8'h30 + 8'(k);
            issue(1'b1, 1'b1, gw);
            if (gw) serve(1'b1, wr_req_len_i, wr_req_id_i, wr_req_addr_i, 1'b0, 1'b0, -1);
            else    serve(1'b0, rd_req_len_i, rd_req_id_i, rd_req_addr_i, 1'b0, 1'b0, -1);
        end

        // enable_i low holds off new grants.
        enable_i = 1'b0;
        wr_req_addr_i = 32'h1000; wr_req_len_i = 4'd3; wr_req_id_i = 8'h5A;
        wr_req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("en_block", 32'(wr_req_ready_o | busy_o), 0);
            step();
        end
        enable_i = 1'b1;
        issue(1'b1, 1'b0, gw);
        serve(1'b1, 4'd3, 8'h5A, 32'h1000, 1'b0, 1'b0, -1);

        rd_req_addr_i = 32'h1800; rd_req_len_i = 4'd0; rd_req_id_i = 8'h11;
        issue(1'b0, 1'b1, gw);
        serve(1'b0, 4'd0, 8'h11, 32'h1800, 1'b1, 1'b0, -1);

        wr_req_addr_i = 32'h5000; wr_req_len_i = 4'd15; wr_req_id_i = 8'hC3;
        issue(1'b1, 1'b0, gw);
        serve(1'b1, 4'd15, 8'hC3, 32'h5000, 1'b0, 1'b1, -1);
        rd_req_addr_i = 32'h6000; rd_req_len_i = 4'd15; rd_req_id_i = 8'h3C;
        issue(1'b0, 1'b1, gw);
        serve(1'b0, 4'd15, 8'h3C, 32'h6000, 1'b0, 1'b1, -1);

        // Clear in mid-burst drops the write without a response.
        wr_req_addr_i = 32'h4000; wr_req_len_i = 4'd7; wr_req_id_i = 8'h77;
        issue(1'b1, 1'b0, gw);
        @(negedge clk);
        check_eq("clr_start", 32'(strm_start_o), 1);
        step();
        wdat_valid_i = 1'b1; strm_wdat_ready_i = 1'b1;
        repeat (2) step();
        pulse_clear();
        @(negedge clk);
        check_eq("clr_busy", 32'(busy_o), 0);
        check_eq("clr_wgate", 32'(strm_wdat_valid_o | wdat_ready_o), 0);
        check_eq("clr_addr", strm_addr_o, 0);
        check_eq("clr_beats", 32'(strm_beats_o), 0);
        wdat_valid_i = 1'b0; strm_wdat_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("clr_no_wrsp", 32'(wrsp_valid_o), 0);
            step();
        end
        wr_req_addr_i = 32'h4400; wr_req_len_i = 4'd2; wr_req_id_i = 8'h78;
        issue(1'b1, 1'b0, gw);
        serve(1'b1, 4'd2, 8'h78, 32'h4400, 1'b1, 1'b0, -1);

        for (int n = 0; n < 8; n++) begin
            dw = 1'($urandom_range(0, 1));
            dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_req_addr_i = $urandom; wr_req_len_i = 4'($urandom); wr_req_id_i = 8'($urandom);
            rd_req_addr_i = $urandom; rd_req_len_i = 4'($urandom); rd_req_id_i = 8'($urandom);
            issue(dw, dr, gw);
            if (gw) serve(1'b1, wr_req_len_i, wr_req_id_i, wr_req_addr_i,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            else    serve(1'b0, rd_req_len_i, rd_req_id_i, rd_req_addr_i,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        // Early last on beat 2 of 4.
`ifdef NVDLA_DBB_SCHED_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        ln = 4'd3;
        wr_req_addr_i = 32'h7000; wr_req_len_i = ln; wr_req_id_i = 8'hE1;
        issue(1'b1, 1'b0, gw);
        serve(1'b1, ln, 8'hE1, 32'h7000, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("err_sticky", 32'(err_o), 32'(exp_err));
            step();
        end
        pulse_clear();
        @(negedge clk);
        check_eq("err_cleared", 32'(err_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
